cache_flush_engine: RTL
=======================

// Module: cache_flush_engine
// PURPOSE
//  Hardware write-back flush for the 32-line direct-mapped data cache. On request it walks every line,
//  writes each valid+dirty line to data memory, and clears its dirty bit. It is the initiator on the
//  MEM_wen/MEM_addr/MEM_wdata/MEM_ready interface, muxed with the cache controller when busy_o=1.
// PARAMETERS
//  LINES    32    cache lines scanned, index 0..LINES-1
//  IDX_W    5     line index width, log2(LINES)
//  TAG_W    22    tag width
//  DATA_W   256   line and memory-word width
//  ADDR_W   27    memory block address width, = TAG_W+IDX_W
//  TIMEOUT  64    max cycles waiting for mem_ready_i per write
// PORTS
//  clk_i         in   1       clock
//  rst_i         in   1       reset, synchronous, active-high
//  flush_req_i   in   1       start flush; sampled only in IDLE
//  busy_o        out  1       engine owns memory port and cache line port
//  flush_done_o  out  1       one-cycle pulse when flush ends
//  err_o         out  1       sticky timeout flag; cleared when the next request is accepted
//  wb_count_o    out  IDX_W+1 lines written back in the current/last flush
//  line_idx_o    out  IDX_W   cache line being examined
//  line_valid_i  in   1       valid bit of line_idx_o, combinational same cycle
//  line_dirty_i  in   1       dirty bit of line_idx_o
//  line_tag_i    in   TAG_W   tag of line_idx_o
//  line_data_i   in   DATA_W  data of line_idx_o
//  dirty_clr_o   out  1       one-cycle pulse: clear dirty bit of line_idx_o
//  mem_wen_o     out  1       memory write request, held until mem_ready_i
//  mem_addr_o    out  ADDR_W  block address = {tag, index}
//  mem_wdata_o   out  DATA_W  write line
//  mem_ready_i   in   1       memory accepted write (1 cycle)
// BEHAVIOUR
//  Reset values: state=IDLE; busy_o, flush_done_o, err_o, dirty_clr_o, mem_wen_o = 0;
//   wb_count_o, line_idx_o, mem_addr_o, mem_wdata_o = 0.
//  FSM states: IDLE, SCAN, WRITE, DONE. Registered outputs. No read requests; mem_ren is never driven.
//  IDLE: flush_req_i=1 at edge k -> SCAN from k+1; idx=0, wb_count=0, err=0. busy_o=1 in every non-IDLE state.
//  SCAN: examine line idx.
//   - valid&dirty: latch addr={line_tag_i,idx} and data -> WRITE.
//   - otherwise (including valid=0, dirty=1): if idx==LINES-1 -> DONE, else idx+1.
//  WRITE: mem_wen_o=1; addr and data are stable for the whole state.
//   - mem_ready_i: dirty_clr_o pulses in that cycle (idx unchanged), wb_count+1, wen drops at next edge;
//     then idx==LINES-1 -> DONE, else idx+1 -> SCAN.
//   - timer reaches TIMEOUT cycles without ready: wen drops, err_o=1, dirty not cleared -> DONE.
//  DONE: flush_done_o=1 for exactly one cycle -> IDLE.
//  Latency, all lines clean: req edge k, done high in cycle k+1+LINES (33 cycles).
//   Each write-back adds (ready wait + 1) cycles.
//  flush_req_i while busy: ignored, not queued.
//  mem_ready_i outside WRITE: ignored.
//  wb_count_o saturates at LINES (never wraps); it holds its value after DONE until the next accepted request.
//  rst_i mid-operation: all outputs at reset values the next cycle; no done pulse; any partial write is abandoned.
//   The memory responder drops a request whose wen falls before ready.
// STRUCTURE
//  cache_pkg: LINES, IDX_W, TAG_W, DATA_W, ADDR_W constants; flush_state_t enum {IDLE,SCAN,WRITE,DONE}.
//  Single module; the timeout counter is inline. No sub-module.
// TESTING
//  1. All lines clean, req -> no mem_wen_o; flush_done_o 33 cycles after req; wb_count_o=0; err_o=0.
//  2. Line 3 dirty tag 0x1, line 17 dirty tag 0x2AB -> writes to addr 0x23 then 0x5571 with matching data;
//     dirty_clr_o at idx 3 and idx 17; wb_count_o=2.
//  3. Line 5 valid=0 dirty=1 -> no write; wb_count_o=0.
//  4. mem_ready_i delayed 10 cycles -> wen, addr and wdata unchanged all 10 cycles; one dirty_clr_o pulse.
//  5. rst_i two cycles into WRITE -> next cycle wen=0, busy=0, no done pulse; new req restarts at idx 0.
//  6. Memory never ready on line 0 -> wen drops after 64 cycles; err_o=1; done pulse; dirty bit kept.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared geometry of the 32-line direct-mapped data cache and the flush engine state encoding.
package cache_pkg;

    localparam int LINES  = 32;
    localparam int IDX_W  = 5;
    localparam int TAG_W  = 22;
    localparam int DATA_W = 256;
    localparam int ADDR_W = TAG_W + IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WRITE,
        DONE
    } flush_state_t;

endpackage

// File: rtl/cache_flush_engine.sv
// Write-back flush engine: walks every cache line, writes valid+dirty lines to memory
// and clears their dirty bits. Owns the memory and line ports while busy_o is high.
module cache_flush_engine
    import cache_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_req_i,
    output logic              busy_o,
    output logic              flush_done_o,
    output logic              err_o,
    output logic [IDX_W:0]    wb_count_o,
    output logic [IDX_W-1:0]  line_idx_o,
    input  logic              line_valid_i,
    input  logic              line_dirty_i,
    input  logic [TAG_W-1:0]  line_tag_i,
    input  logic [DATA_W-1:0] line_data_i,
    output logic              dirty_clr_o,
    output logic              mem_wen_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);
    localparam logic [IDX_W:0]   WB_MAX   = (IDX_W + 1)'(LINES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    flush_state_t      state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W:0]    wb_cnt_q, wb_cnt_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            wb_cnt_q <= '0;
            tmr_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wb_cnt_q <= wb_cnt_d;
            tmr_q    <= tmr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Memory handshake: mem_wen_o is the valid; once raised, addr/wdata stay frozen until the
    // cycle mem_ready_i is seen high (transfer), after which wen falls on the next edge.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wb_cnt_d = wb_cnt_q;
        tmr_d    = tmr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        wen_d    = wen_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE: begin
                if (flush_req_i) begin
                    state_d  = SCAN;
                    idx_d    = '0;
                    wb_cnt_d = '0;
                    err_d    = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            SCAN: begin
                if (line_valid_i && line_dirty_i) begin
                    addr_d  = {line_tag_i, idx_q};
                    wdata_d = line_data_i;
                    wen_d   = 1'b1;
                    tmr_d   = '0;
                    state_d = WRITE;
                end else if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            WRITE: begin
                if (mem_ready_i) begin
                    wen_d = 1'b0;
                    if (wb_cnt_q != WB_MAX) begin
                        wb_cnt_d = wb_cnt_q + 1'b1;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = SCAN;
                    end
                end else if (tmr_q == TMR_LAST) begin
                    wen_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // The dirty clear must land in the very cycle the memory accepts, so it is decoded, not registered.
    assign dirty_clr_o  = (state_q == WRITE) && mem_ready_i;
    assign busy_o       = busy_q;
    assign flush_done_o = done_q;
    assign err_o        = err_q;
    assign wb_count_o   = wb_cnt_q;
    assign line_idx_o   = idx_q;
    assign mem_wen_o    = wen_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;

endmodule
